// File: rtl/rf_write_arbiter.sv
// Purpose: shares the single register-file write port between writeback and
//          buffered multiply/divide results. Writeback normally wins, and
//          buffered results drain in order whenever the port is free.
// Latency: rf_* are combinational in the grant cycle. A pushed MDU result can
//          reach the port no earlier than the cycle after its push.
// Backpressure: mdu_ready drops while the FIFO is full. A head denied
//          STARVE_LIMIT cycles raises stall_wb for one cycle, and that cycle
//          writes the head.
// Ports: clk/rst (sync, active-high); wb_* writeback request; mdu_* result
//        push with mdu_ready; stall_wb to hold writeback; rf_* write port;
//        src1/src2 -> pend_hit1/2 hazard flags; fifo_count stored entries.
module rf_write_arbiter #(
  parameter int WORD_LEN     = 32,
  parameter int ADDR_LEN     = 5,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_en,
  input  logic [ADDR_LEN-1:0]      wb_dest,
  input  logic [WORD_LEN-1:0]      wb_val,
  input  logic                     mdu_valid,
  input  logic [ADDR_LEN-1:0]      mdu_dest,
  input  logic [WORD_LEN-1:0]      mdu_val,
  output logic                     mdu_ready,
  output logic                     stall_wb,
  output logic                     rf_we,
  output logic [ADDR_LEN-1:0]      rf_dest,
  output logic [WORD_LEN-1:0]      rf_wval,
  input  logic [ADDR_LEN-1:0]      src1,
  input  logic [ADDR_LEN-1:0]      src2,
  output logic                     pend_hit1,
  output logic                     pend_hit2,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [ADDR_LEN-1:0] dest_q [DEPTH];
  logic [ADDR_LEN-1:0] dest_d [DEPTH];
  logic [WORD_LEN-1:0] val_q  [DEPTH];
  logic [WORD_LEN-1:0] val_d  [DEPTH];
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [SW-1:0]       starve_q, starve_d;

  logic empty;
  logic wb_live;
  logic push_store;
  logic head_grant;

  // Grant and write-port muxing.
  always_comb begin
    empty      = (count_q == '0);
    // A writeback to r0 is a no-op and leaves the port free for the FIFO.
    wb_live    = wb_en && (wb_dest != '0);
    mdu_ready  = !rst && (count_q < FULL_CNT);
    // r0 results are accepted so the MDU is not blocked, but never stored.
    push_store = mdu_valid && mdu_ready && (mdu_dest != '0);
    stall_wb   = !rst && !empty && (starve_q == STARVE_MAX);
    head_grant = !rst && !empty && (stall_wb || !wb_live);

    rf_we   = 1'b0;
    rf_dest = '0;
    rf_wval = '0;
    if (head_grant) begin
      rf_we   = 1'b1;
      rf_dest = dest_q[rd_ptr_q];
      rf_wval = val_q[rd_ptr_q];
    end else if (!rst && wb_live) begin
      rf_we   = 1'b1;
      rf_dest = wb_dest;
      rf_wval = wb_val;
    end
  end

  // Hazard flags look only at stored entries, never the incoming push.
  always_comb begin
    pend_hit1 = 1'b0;
    pend_hit2 = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count_q) begin
        if (dest_q[rd_ptr_q + PW'(k)] == src1) pend_hit1 = 1'b1;
        if (dest_q[rd_ptr_q + PW'(k)] == src2) pend_hit2 = 1'b1;
      end
    end
    pend_hit1 = pend_hit1 && !rst && (src1 != '0);
    pend_hit2 = pend_hit2 && !rst && (src2 != '0);
  end

  // FIFO pointers, occupancy and starvation counter.
  always_comb begin
    dest_d   = dest_q;
    val_d    = val_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    starve_d = starve_q;

    if (push_store) begin
      dest_d[wr_ptr_q] = mdu_dest;
      val_d[wr_ptr_q]  = mdu_val;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (head_grant) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push_store) - CW'(head_grant);

    // Restart the wait for every new head; saturate while it keeps losing.
    if (empty || head_grant) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
    // Storage needs no reset; occupancy alone decides what is valid.
    dest_q <= dest_d;
    val_q  <= val_d;
  end

  assign fifo_count = count_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
  localparam int WL = 32;
  localparam int AL = 5;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, wb_en, mdu_valid, mdu_ready, stall_wb, rf_we;
  logic          pend_hit1, pend_hit2;
  logic [AL-1:0] wb_dest, mdu_dest, rf_dest, src1, src2;
  logic [WL-1:0] wb_val, mdu_val, rf_wval;
  logic [1:0]    fifo_count;

  int checks = 0;
  int failures = 0;

  rf_write_arbiter #(.WORD_LEN(WL), .ADDR_LEN(AL), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_val(wb_val),
    .mdu_valid(mdu_valid), .mdu_dest(mdu_dest), .mdu_val(mdu_val), .mdu_ready(mdu_ready),
    .stall_wb(stall_wb), .rf_we(rf_we), .rf_dest(rf_dest), .rf_wval(rf_wval),
    .src1(src1), .src2(src2), .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
    .fifo_count(fifo_count)
  );

  // Reference model: an ordered list of waiting results plus how many
  // cycles the current head has been passed over.
  typedef struct packed {
    logic [AL-1:0] d;
    logic [WL-1:0] v;
  } ent_t;
  ent_t mq[$];
  int   mwait = 0;

  function automatic bit m_ready();
    return !rst && (mq.size() < DEPTH);
  endfunction

  function automatic bit m_stall();
    return !rst && (mq.size() > 0) && (mwait == LIMIT);
  endfunction

  // 0: port idle, 1: writeback owns the port, 2: oldest buffered result
  function automatic int m_grant();
    if (rst) return 0;
    if (m_stall()) return 2;
    if (wb_en && wb_dest != 0) return 1;
    if (mq.size() > 0) return 2;
    return 0;
  endfunction

  function automatic logic [AL-1:0] m_dest();
    int g = m_grant();
    if (g == 1) return wb_dest;
    if (g == 2) return mq[0].d;
    return '0;
  endfunction

  function automatic logic [WL-1:0] m_wval();
    int g = m_grant();
    if (g == 1) return wb_val;
    if (g == 2) return mq[0].v;
    return '0;
  endfunction

  function automatic bit m_pend(input logic [AL-1:0] s);
    if (rst || s == 0) return 1'b0;
    foreach (mq[i]) if (mq[i].d == s) return 1'b1;
    return 1'b0;
  endfunction

  // Advance one clock, applying the same input set to the model.
  task automatic tick();
    int g = m_grant();
    bit psh = m_ready() && mdu_valid && (mdu_dest != 0);
    bit was_empty = (mq.size() == 0);
    ent_t e;
    e.d = mdu_dest;
    e.v = mdu_val;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mwait = 0;
    end else begin
      if (g == 2) void'(mq.pop_front());
      if (psh) mq.push_back(e);
      if (was_empty || g == 2) mwait = 0;
      else if (mwait < LIMIT) mwait = mwait + 1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    wb_en = 0; wb_dest = 0; wb_val = 0;
    mdu_valid = 0; mdu_dest = 0; mdu_val = 0;
    src1 = 0; src2 = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    #1;
    checks++; if (mdu_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", mdu_ready); end
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b exp=0", rf_we); end
    tick();
    tick();
    checks++; if (fifo_count !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (stall_wb !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall_wb); end
    checks++; if ({rf_dest, rf_wval} !== '0) begin failures++; $display("FAIL reset_rf got=%0h/%0h exp=0/0", rf_dest, rf_wval); end
    checks++; if ({pend_hit1, pend_hit2} !== 2'b00) begin failures++; $display("FAIL reset_pend got=%b exp=00", {pend_hit1, pend_hit2}); end
    rst = 0;
    #1;
    checks++; if (mdu_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after got=%0b exp=1", mdu_ready); end
    tick();
  endtask

  task automatic test_idle_drain();
    idle_inputs();
    mdu_valid = 1; mdu_dest = 5; mdu_val = 32'hDEADBEEF; src1 = 5;
    #1;
    checks++; if (pend_hit1 !== 1'b0) begin failures++; $display("FAIL drain_pend_pushcycle got=%0b exp=0", pend_hit1); end
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL drain_no_bypass got=%0b exp=0", rf_we); end
    tick();
    mdu_valid = 0;
    #1;
    checks++; if (fifo_count !== 2'd1) begin failures++; $display("FAIL drain_count1 got=%0d exp=1", fifo_count); end
    checks++; if (pend_hit1 !== 1'b1) begin failures++; $display("FAIL drain_pend got=%0b exp=1", pend_hit1); end
    checks++; if ({rf_we, rf_dest, rf_wval} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin failures++; $display("FAIL drain_write got=%0b/%0d/%0h exp=1/5/deadbeef", rf_we, rf_dest, rf_wval); end
    tick();
    checks++; if (fifo_count !== 2'd0) begin failures++; $display("FAIL drain_count0 got=%0d exp=0", fifo_count); end
    checks++; if ({rf_we, pend_hit1} !== 2'b00) begin failures++; $display("FAIL drain_after got=%b exp=00", {rf_we, pend_hit1}); end
  endtask

  task automatic test_priority();
    idle_inputs();
    mdu_valid = 1; mdu_dest = 7; mdu_val = 32'h7777_0007;
    #1;
    tick();
    mdu_valid = 0; wb_en = 1; wb_dest = 3; wb_val = 32'h3333_0003;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if ({rf_we, rf_dest, rf_wval} !== {1'b1, 5'd3, 32'h3333_0003}) begin failures++; $display("FAIL prio_wb%0d got=%0b/%0d/%0h exp=1/3/33330003", c, rf_we, rf_dest, rf_wval); end
      tick();
    end
    wb_en = 0;
    #1;
    checks++; if ({rf_we, rf_dest, rf_wval} !== {1'b1, 5'd7, 32'h7777_0007}) begin failures++; $display("FAIL prio_head got=%0b/%0d/%0h exp=1/7/77770007", rf_we, rf_dest, rf_wval); end
    tick();
  endtask

  task automatic test_starvation();
    idle_inputs();
    mdu_valid = 1; mdu_dest = 9; mdu_val = 32'h0000_9999;
    #1;
    tick();
    mdu_valid = 0; wb_en = 1; wb_dest = 4; wb_val = 32'h4444;
    for (int c = 1; c <= LIMIT; c++) begin
      #1;
      checks++; if ({stall_wb, rf_dest} !== {1'b0, 5'd4}) begin failures++; $display("FAIL starve_wait%0d got=%0b/%0d exp=0/4", c, stall_wb, rf_dest); end
      tick();
    end
    #1;
    checks++; if ({stall_wb, rf_we, rf_dest, rf_wval} !== {1'b1, 1'b1, 5'd9, 32'h0000_9999}) begin failures++; $display("FAIL starve_force got=%0b/%0b/%0d/%0h exp=1/1/9/9999", stall_wb, rf_we, rf_dest, rf_wval); end
    tick();
    checks++; if ({stall_wb, rf_dest, fifo_count} !== {1'b0, 5'd4, 2'd0}) begin failures++; $display("FAIL starve_after got=%0b/%0d/%0d exp=0/4/0", stall_wb, rf_dest, fifo_count); end
    wb_en = 0;
    tick();
  endtask

  task automatic test_full_backpressure();
    logic [AL-1:0] dl [3];
    logic [AL-1:0] order[$];
    int  idx = 0;
    bit  saw_full = 0;
    bit  acc;
    dl[0] = 10; dl[1] = 11; dl[2] = 12;
    idle_inputs();
    wb_en = 1; wb_dest = 1; wb_val = 32'h1111;
    for (int c = 0; c < 30; c++) begin
      mdu_valid = (idx < 3);
      mdu_dest  = (idx < 3) ? dl[idx] : 5'd0;
      mdu_val   = 32'hA000 + idx;
      #1;
      checks++; if (mdu_ready !== m_ready()) begin failures++; $display("FAIL full_ready c%0d got=%0b exp=%0b", c, mdu_ready, m_ready()); end
      checks++; if ({stall_wb, fifo_count} !== {m_stall(), 2'(mq.size())}) begin failures++; $display("FAIL full_state c%0d got=%0b/%0d exp=%0b/%0d", c, stall_wb, fifo_count, m_stall(), mq.size()); end
      checks++; if ({rf_dest, rf_wval} !== {m_dest(), m_wval()}) begin failures++; $display("FAIL full_port c%0d got=%0d/%0h exp=%0d/%0h", c, rf_dest, rf_wval, m_dest(), m_wval()); end
      if (rf_we && rf_dest != 1) order.push_back(rf_dest);
      if (fifo_count == 2 && mdu_valid && !mdu_ready) saw_full = 1;
      acc = mdu_valid && mdu_ready;
      tick();
      if (acc) idx++;
    end
    checks++; if (saw_full !== 1'b1) begin failures++; $display("FAIL full_seen got=%0b exp=1", saw_full); end
    checks++; if (order.size() != 3) begin failures++; $display("FAIL full_order_len got=%0d exp=3", order.size()); end
    for (int i = 0; i < order.size() && i < 3; i++) begin
      checks++; if (order[i] !== dl[i]) begin failures++; $display("FAIL full_order%0d got=%0d exp=%0d", i, order[i], dl[i]); end
    end
    wb_en = 0;
    tick();
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    mdu_valid = 1; mdu_dest = 0; mdu_val = 32'hBAD0;
    #1;
    checks++; if (mdu_ready !== 1'b1) begin failures++; $display("FAIL zero_ready got=%0b exp=1", mdu_ready); end
    tick();
    mdu_valid = 0;
    #1;
    checks++; if ({fifo_count, rf_we} !== {2'd0, 1'b0}) begin failures++; $display("FAIL zero_discard got=%0d/%0b exp=0/0", fifo_count, rf_we); end
    mdu_valid = 1; mdu_dest = 6; mdu_val = 32'h6666;
    tick();
    mdu_valid = 0; wb_en = 1; wb_dest = 0; wb_val = 32'hBAD1;
    #1;
    checks++; if ({rf_we, rf_dest, rf_wval} !== {1'b1, 5'd6, 32'h6666}) begin failures++; $display("FAIL zero_wb_drain got=%0b/%0d/%0h exp=1/6/6666", rf_we, rf_dest, rf_wval); end
    tick();
    checks++; if ({fifo_count, rf_we} !== {2'd0, 1'b0}) begin failures++; $display("FAIL zero_after got=%0d/%0b exp=0/0", fifo_count, rf_we); end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    wb_en = 1; wb_dest = 2; wb_val = 32'h2222;
    mdu_valid = 1; mdu_dest = 20; mdu_val = 32'h20;
    #1;
    tick();
    mdu_dest = 21; mdu_val = 32'h21;
    tick();
    mdu_valid = 0; src1 = 20; src2 = 21;
    #1;
    checks++; if ({fifo_count, pend_hit1, pend_hit2} !== {2'd2, 2'b11}) begin failures++; $display("FAIL rmid_before got=%0d/%b exp=2/11", fifo_count, {pend_hit1, pend_hit2}); end
    rst = 1;
    #1;
    checks++; if ({rf_we, stall_wb, mdu_ready} !== 3'b000) begin failures++; $display("FAIL rmid_during got=%b exp=000", {rf_we, stall_wb, mdu_ready}); end
    tick();
    rst = 0; wb_en = 0;
    #1;
    checks++; if ({fifo_count, rf_we, pend_hit1, pend_hit2} !== 5'b0) begin failures++; $display("FAIL rmid_after got=%0d/%b exp=0/000", fifo_count, {rf_we, pend_hit1, pend_hit2}); end
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rmid_stale%0d got=%0b exp=0", c, rf_we); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      rst       = ($urandom_range(0, 79) == 0);
      wb_en     = ($urandom_range(0, 3) != 0);
      wb_dest   = 5'($urandom_range(0, 3));
      wb_val    = $urandom;
      mdu_valid = $urandom_range(0, 1);
      mdu_dest  = 5'($urandom_range(0, 3));
      mdu_val   = $urandom;
      src1      = 5'($urandom_range(0, 3));
      src2      = 5'($urandom_range(0, 3));
      #1;
      checks++; if ({mdu_ready, stall_wb, fifo_count} !== {m_ready(), m_stall(), 2'(mq.size())}) begin failures++; $display("FAIL rnd_ctrl c%0d got=%0b/%0b/%0d exp=%0b/%0b/%0d", c, mdu_ready, stall_wb, fifo_count, m_ready(), m_stall(), mq.size()); end
      checks++; if ({rf_we, rf_dest, rf_wval} !== {m_grant() != 0, m_dest(), m_wval()}) begin failures++; $display("FAIL rnd_port c%0d got=%0b/%0d/%0h exp=%0b/%0d/%0h", c, rf_we, rf_dest, rf_wval, m_grant() != 0, m_dest(), m_wval()); end
      checks++; if ({pend_hit1, pend_hit2} !== {m_pend(src1), m_pend(src2)}) begin failures++; $display("FAIL rnd_pend c%0d got=%b exp=%b", c, {pend_hit1, pend_hit2}, {m_pend(src1), m_pend(src2)}); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_idle_drain();
    test_priority();
    test_starvation();
    test_full_backpressure();
    test_zero_reg();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
